// File: rtl/get_val_pkg.sv
// Shared types, filter coefficients and constant-multiply helper for the
// 8-tap luma fractional-sample filter (get_val_mirror_add).
package get_val_pkg;

    typedef logic [7:0]  pixel_t;
    typedef logic [31:0] word_t;

    localparam int APPROX_BITS_DEFAULT = 4;

    localparam int COEF_A [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
    localparam int COEF_B [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int COEF_C [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

    // Set 0 = quarter (a), 1 = half (b), 2 = three-quarter (c).
    function automatic int coef_of(input int set, input int tap);
        case (set)
            0:       return COEF_A[tap];
            1:       return COEF_B[tap];
            default: return COEF_C[tap];
        endcase
    endfunction

    // Exact constant product: shift-and-add of |coef|, then two's-complement negate.
    function automatic word_t mul_const(input word_t d, input int coef);
        word_t acc;
        int    mag;
        acc = '0;
        mag = (coef < 0) ? -coef : coef;
        for (int k = 0; k < 8; k++) begin
            if (mag[k]) begin
                acc = acc + (d << k);
            end
        end
        if (coef < 0) begin
            acc = ~acc + word_t'(1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mirror_add32.sv
// 32-bit ripple mirror adder; with MIRROR_APPROX_EN defined the low APPROX_BITS
// positions use the approximate cell (sum = b, carry-out = a).
module mirror_add32
    import get_val_pkg::*;
#(
    parameter int APPROX_BITS = APPROX_BITS_DEFAULT
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

`ifdef MIRROR_APPROX_EN
    localparam int LOW_BITS = APPROX_BITS;
`else
    localparam int LOW_BITS = APPROX_BITS * 0;
`endif

    logic [32:0] carry;
    logic        unused_carry;

    assign carry[0]     = 1'b0;
    assign unused_carry = carry[32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            if (gi < LOW_BITS) begin : g_approx
                assign sum[gi]      = b[gi];
                assign carry[gi+1]  = a[gi];
            end else begin : g_exact
                assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
                assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/get_val_mirror_add.sv
// 8-tap luma filter producing registered a/b/c sums through ordered mirror-adder
// trees. Approximate low adder bits are enabled by the MIRROR_APPROX_EN macro.
module get_val_mirror_add
    import get_val_pkg::*;
#(
    parameter int APPROX_BITS = APPROX_BITS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0][7:0]  data_buffer,
    output logic [31:0]      aValue,
    output logic [31:0]      bValue,
    output logic [31:0]      cValue
);

    word_t prod  [3][8];
    word_t lvl1  [3][4];
    word_t lvl2  [3][2];
    word_t total [3];
    word_t value_reg [3];

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_set
            // Tap t reads data_buffer[7-t]: the oldest pixel meets coefficient 0.
            for (gj = 0; gj < 8; gj++) begin : g_tap
                assign prod[gi][gj] = mul_const(word_t'(data_buffer[7-gj]), coef_of(gi, gj));
            end

            for (gj = 0; gj < 4; gj++) begin : g_l1
                mirror_add32 #(.APPROX_BITS(APPROX_BITS)) u_add (
                    .a   (prod[gi][2*gj]),
                    .b   (prod[gi][2*gj+1]),
                    .sum (lvl1[gi][gj])
                );
            end

            for (gj = 0; gj < 2; gj++) begin : g_l2
                mirror_add32 #(.APPROX_BITS(APPROX_BITS)) u_add (
                    .a   (lvl1[gi][2*gj]),
                    .b   (lvl1[gi][2*gj+1]),
                    .sum (lvl2[gi][gj])
                );
            end

            mirror_add32 #(.APPROX_BITS(APPROX_BITS)) u_root (
                .a   (lvl2[gi][0]),
                .b   (lvl2[gi][1]),
                .sum (total[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                value_reg[k] <= '0;
            end else begin
                value_reg[k] <= total[k];
            end
        end
    end

    assign aValue = value_reg[0];
    assign bValue = value_reg[1];
    assign cValue = value_reg[2];

endmodule

// File: tb/tb_get_val_mirror_add.sv
// Directed self-checking bench for get_val_mirror_add and one mirror_add32 unit.
module tb_get_val_mirror_add;

    logic            clock;
    logic            reset;
    logic [7:0][7:0] data_buffer;
    logic [31:0]     aValue, bValue, cValue;
    logic [31:0]     unit_a, unit_b, unit_sum;

    int total = 0;
    int bad   = 0;

    get_val_mirror_add #(.APPROX_BITS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_buffer (data_buffer),
        .aValue      (aValue),
        .bValue      (bValue),
        .cValue      (cValue)
    );

    mirror_add32 #(.APPROX_BITS(4)) u_unit (
        .a   (unit_a),
        .b   (unit_b),
        .sum (unit_sum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %-12s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            bad++;
            $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] ec);
        check({tag, ".a"}, aValue, ea);
        check({tag, ".b"}, bValue, eb);
        check({tag, ".c"}, cValue, ec);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    localparam logic [63:0] W_ZERO = 64'h0;
    localparam logic [63:0] W_64   = {8{8'd64}};
    localparam logic [63:0] W_ONES = {8{8'd1}};
    localparam logic [63:0] W_RAMP = {8'd0, 8'd8, 8'd17, 8'd25, 8'd34, 8'd42, 8'd51, 8'd59};
    localparam logic [63:0] W_D2   = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    logic [63:0] s_win   [6];
    logic        s_rst   [6];
    logic [31:0] s_exp_a [6];
    logic [31:0] s_exp_b [6];
    logic [31:0] s_exp_c [6];

    initial begin
        reset       = 1'b1;
        data_buffer = 64'hDEAD_BEEF_0123_4567;
        unit_a      = '0;
        unit_b      = '0;

        // Reset held with arbitrary data: outputs stay 0 on every edge.
        for (int i = 0; i < 3; i++) begin
            data_buffer = {$urandom, $urandom};
            step();
            check3("rst_hold", 32'h0, 32'h0, 32'h0);
        end

        reset       = 1'b0;
        data_buffer = W_ZERO;
        for (int i = 0; i < 2; i++) begin
            step();
            check3("zero_win", 32'h0, 32'h0, 32'h0);
        end

        // All-ones window: 64 in both exact and approximate (4-bit) builds.
        data_buffer = W_ONES;
        step();
        check("ones.a", aValue, 32'd64);
`ifndef MIRROR_APPROX_EN
        check("ones.b", bValue, 32'd64);
        check("ones.c", cValue, 32'd64);
`endif

        unit_a = 32'hFFFF_FFFF;
        unit_b = 32'd4;
        #1;
`ifdef MIRROR_APPROX_EN
        check("unit_add", unit_sum, 32'd4);
`else
        check("unit_add", unit_sum, 32'd3);
`endif

`ifndef MIRROR_APPROX_EN
        data_buffer = W_64;
        step();
        check3("all64", 32'd4096, 32'd4096, 32'd4096);

        data_buffer = W_RAMP;
        step();
        check3("ramp", 32'd1731, 32'd1888, 32'd2045);

        data_buffer = W_D2;
        step();
        check3("d2_255", 32'hFFFF_F60A, 32'hFFFF_F50B, 32'hFFFF_FB05);

        // Back-to-back windows with a one-cycle reset pulse at step 3.
        s_win = '{W_64, W_RAMP, W_D2, W_ONES, W_ONES, W_RAMP};
        s_rst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        s_exp_a = '{32'd4096, 32'd1731, 32'hFFFF_F60A, 32'd0, 32'd64, 32'd1731};
        s_exp_b = '{32'd4096, 32'd1888, 32'hFFFF_F50B, 32'd0, 32'd64, 32'd1888};
        s_exp_c = '{32'd4096, 32'd2045, 32'hFFFF_FB05, 32'd0, 32'd64, 32'd2045};
        for (int i = 0; i < 6; i++) begin
            data_buffer = s_win[i];
            reset       = s_rst[i];
            step();
            check3($sformatf("stream%0d", i), s_exp_a[i], s_exp_b[i], s_exp_c[i]);
        end
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
